// File: rtl/dds_modulator_if.sv
// Control and sample bus of the DDS modulator: host-side controls in, DAC-side samples out.
interface dds_modulator_if #(
    parameter int unsigned PHASE_W = 32
) ();
    logic               i_en;
    logic [1:0]         i_mode;
    logic [PHASE_W-1:0] i_fword0;
    logic [PHASE_W-1:0] i_fword1;
    logic               i_data_sel;
    logic               i_data_in;
    logic [9:0]         o_dac_data;
    logic               o_sample_vld;
    logic               o_sym_strobe;
    logic               o_cur_bit;

    modport master (
        output i_en, i_mode, i_fword0, i_fword1, i_data_sel, i_data_in,
        input  o_dac_data, o_sample_vld, o_sym_strobe, o_cur_bit
    );

    modport slave (
        input  i_en, i_mode, i_fword0, i_fword1, i_data_sel, i_data_in,
        output o_dac_data, o_sample_vld, o_sym_strobe, o_cur_bit
    );
endinterface

// File: rtl/dds_modulator.sv
// DDS sine carrier with ASK/FSK/BPSK keying from a PN7 or external symbol stream.
// Three-stage sample pipeline: quadrant/address fold, quarter-wave ROM, offset-binary output.
module dds_modulator #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned SYM_DIV = 50000,
    parameter logic [6:0]  PN_SEED = 7'h7F
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    dds_modulator_if.slave bus
);
    localparam int unsigned    CntW    = $clog2(SYM_DIV);
    localparam logic [CntW-1:0] SymLast = CntW'(SYM_DIV - 1);

    // Elaboration-time round(511*sin(pi/2*(k+0.5)/256)) in Q30 fixed point (Taylor to x^17).
    function automatic logic [8:0] quarter_sine(input int unsigned k);
        longint x;
        longint x2;
        longint term;
        longint sum;
        x    = (64'sd3373259426 * longint'(2 * k + 1)) / 64'sd1024;
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int n = 1; n <= 8; n++) begin
            term = -((term * x2) >>> 30) / longint'(2 * n * (2 * n + 1));
            sum  = sum + term;
        end
        return 9'((sum * 64'sd511 + (64'sd1 <<< 29)) >>> 30);
    endfunction

    logic [8:0] w_rom [256];
    for (genvar k = 0; k < 256; k++) begin : g_rom
        assign w_rom[k] = quarter_sine(k);
    end

    logic [PHASE_W-1:0] r_phase_acc;
    logic [CntW-1:0]    r_sym_cnt;
    logic [6:0]         r_pn;
    logic               r_cur_bit;
    logic               r_s1_neg;
    logic [7:0]         r_s1_addr;
    logic [1:0]         r_s1_mode;
    logic               r_s1_bit;
    logic [8:0]         r_s2_m;
    logic               r_s2_neg;
    logic               r_s2_mute;
    logic [9:0]         r_dac;
    logic [2:0]         r_vld;

    logic               w_sym_end;
    logic               w_new_bit;
    logic [PHASE_W-1:0] w_inc;
    logic [1:0]         w_q;
    logic [7:0]         w_addr;
    logic [9:0]         w_dac;
    logic               w_unused_phase;

    assign w_sym_end      = (r_sym_cnt == SymLast);
    assign w_new_bit      = bus.i_data_sel ? bus.i_data_in : r_pn[6];
    assign w_inc          = (bus.i_mode == 2'b10 && r_cur_bit) ? bus.i_fword1 : bus.i_fword0;
    assign w_unused_phase = ^r_phase_acc[PHASE_W-11:0];

    // BPSK rotates by two quadrants; odd quadrants read the quarter table backwards.
    always_comb begin
        w_q    = r_phase_acc[PHASE_W-1 -: 2];
        w_addr = r_phase_acc[PHASE_W-3 -: 8];
        if (bus.i_mode == 2'b11 && r_cur_bit) begin
            w_q = w_q + 2'd2;
        end
        if (w_q[0]) begin
            w_addr = 8'd255 - w_addr;
        end
    end

    always_comb begin
        w_dac = 10'd512;
        if (!r_s2_mute) begin
            w_dac = r_s2_neg ? (10'd512 - {1'b0, r_s2_m}) : (10'd512 + {1'b0, r_s2_m});
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_phase_acc <= '0;
            r_sym_cnt   <= '0;
            r_pn        <= PN_SEED;
            r_cur_bit   <= 1'b0;
            r_s1_neg    <= 1'b0;
            r_s1_addr   <= '0;
            r_s1_mode   <= '0;
            r_s1_bit    <= 1'b0;
            r_s2_m      <= '0;
            r_s2_neg    <= 1'b0;
            r_s2_mute   <= 1'b0;
            r_dac       <= 10'd512;
        end else if (bus.i_en) begin
            r_phase_acc <= r_phase_acc + w_inc;
            if (w_sym_end) begin
                r_sym_cnt <= '0;
                r_cur_bit <= w_new_bit;
                r_pn      <= {r_pn[5:0], r_pn[6] ^ r_pn[5]};
            end else begin
                r_sym_cnt <= r_sym_cnt + 1'b1;
            end
            r_s1_neg  <= w_q[1];
            r_s1_addr <= w_addr;
            r_s1_mode <= bus.i_mode;
            r_s1_bit  <= r_cur_bit;
            r_s2_m    <= w_rom[r_s1_addr];
            r_s2_neg  <= r_s1_neg;
            r_s2_mute <= (r_s1_mode == 2'b01) && !r_s1_bit;
            r_dac     <= w_dac;
        end
    end

    // Valid keeps shifting while frozen so it drains three cycles after en drops.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[1:0], bus.i_en};
        end
    end

    assign bus.o_dac_data   = r_dac;
    assign bus.o_sample_vld = r_vld[2];
    assign bus.o_sym_strobe = bus.i_en && w_sym_end;
    assign bus.o_cur_bit    = r_cur_bit;
endmodule

// File: tb/tb_dds_modulator.sv
// Directed bench for dds_modulator: reset, carrier, BPSK, ASK, FSK, PN7 stream and enable hold.
module tb_dds_modulator;
    localparam int unsigned PHASE_W = 32;
    localparam int unsigned SYM_DIV = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    int         t;
    int         n_vec = 0;
    int         n_err = 0;
    int         ones;
    int         per_err;
    string      tag;
    logic [9:0] exp_dac;
    logic [9:0] car [4];
    logic [9:0] eig [8];
    int         fu [24];
    logic       pn_exp [7];
    logic       bits [254];

    dds_modulator_if #(.PHASE_W(PHASE_W)) bus ();

    dds_modulator #(
        .PHASE_W(PHASE_W),
        .SYM_DIV(SYM_DIV),
        .PN_SEED(7'h7F)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            t++;
        end
    endtask

    task automatic chk10(input string name, input logic [9:0] obs, input logic [9:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s t=%0d: observed %0d expected %0d", name, t, obs, exp_v);
        end
    endtask

    task automatic chk1(input string name, input logic obs, input logic exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s t=%0d: observed %b expected %b", name, t, obs, exp_v);
        end
    endtask

    task automatic chkn(input string name, input int obs, input int exp_v);
        n_vec++;
        assert (obs == exp_v) else begin
            n_err++;
            $error("FAIL %s t=%0d: observed %0d expected %0d", name, t, obs, exp_v);
        end
    endtask

    initial begin
        // Quarter-phase carrier samples, and eighth-phase samples (m[128]=362, m[127]=360).
        car    = '{10'd514, 10'd1023, 10'd510, 10'd1};
        eig    = '{10'd514, 10'd874, 10'd1023, 10'd872, 10'd510, 10'd150, 10'd1, 10'd152};
        // Accumulator in units of 2^29 after edges 44..67 across the FSK bit changes.
        fu     = '{0, 2, 4, 6, 0, 1, 2, 3, 4, 5, 6, 7, 0, 2, 4, 6, 0, 2, 4, 6, 0, 1, 2, 3};
        // PN7 output from seed 7F after eight earlier strobes.
        pn_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        t = 0;
        rst_n           = 1'b0;
        bus.i_en        = 1'b1;
        bus.i_mode      = 2'b00;
        bus.i_fword0    = 32'h4000_0000;
        bus.i_fword1    = 32'h0000_0000;
        bus.i_data_sel  = 1'b1;
        bus.i_data_in   = 1'b0;
        tick(2);
        chk10("rst_dac", bus.o_dac_data, 10'd512);
        chk1("rst_vld", bus.o_sample_vld, 1'b0);
        chk1("rst_strobe", bus.o_sym_strobe, 1'b0);
        chk1("rst_bit", bus.o_cur_bit, 1'b0);

        rst_n = 1'b1;
        t = 0;
        tick(2);
        chk1("vld_latency", bus.o_sample_vld, 1'b0);
        tick(1);
        chk10("carrier_first", bus.o_dac_data, 10'd514);
        chk1("carrier_vld", bus.o_sample_vld, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick(1);
            chk10("carrier_dac", bus.o_dac_data, car[2'((t - 3) % 4)]);
            chk1("carrier_strobe", bus.o_sym_strobe, (t % 8) == 7);
        end

        bus.i_mode    = 2'b11;
        bus.i_data_in = 1'b1;
        for (int i = 0; i < 36; i++) begin
            tick(1);
            if (t >= 19 && t <= 26) exp_dac = car[2'((t - 1) % 4)];
            else if (t >= 33 && t <= 42) exp_dac = 10'd512;
            else exp_dac = car[2'((t - 3) % 4)];
            if (t < 31) tag = "bpsk_dac";
            else tag = "ask_dac";
            chk10(tag, bus.o_dac_data, exp_dac);
            chk1("sym_strobe", bus.o_sym_strobe, (t % 8) == 7);
            chk1("cur_bit", bus.o_cur_bit, (t >= 16 && t <= 23) || t >= 40);
            if (t == 19) bus.i_data_in = 1'b0;
            if (t == 30) bus.i_mode = 2'b01;
            if (t == 32) bus.i_data_in = 1'b1;
        end

        bus.i_mode    = 2'b10;
        bus.i_fword0  = 32'h2000_0000;
        bus.i_fword1  = 32'h4000_0000;
        bus.i_data_in = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick(1);
            chk10("fsk_dac", bus.o_dac_data, eig[3'(fu[5'(t - 47)])]);
            chk1("fsk_bit", bus.o_cur_bit, (t == 47) || (t >= 56 && t <= 63));
            if (t == 48) bus.i_data_in = 1'b1;
            if (t == 56) bus.i_data_in = 1'b0;
        end

        bus.i_mode     = 2'b00;
        bus.i_fword0   = 32'h4000_0000;
        bus.i_data_sel = 1'b0;
        tick(2);
        for (int k = 0; k < 254; k++) begin
            if (k > 0) tick(8);
            bits[8'(k)] = bus.o_cur_bit;
            if (k < 7) chk1("pn_bit", bus.o_cur_bit, pn_exp[3'(k)]);
        end
        ones    = 0;
        per_err = 0;
        for (int k = 0; k < 127; k++) begin
            if (bits[8'(k)] === 1'b1) ones++;
            if (bits[8'(k)] !== bits[8'(k + 127)]) per_err++;
        end
        chkn("pn_ones", ones, 64);
        chkn("pn_period", per_err, 0);

        chk10("pre_hold_dac", bus.o_dac_data, 10'd510);
        bus.i_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk10("hold_dac", bus.o_dac_data, 10'd510);
            chk1("hold_strobe", bus.o_sym_strobe, 1'b0);
            chk1("hold_vld", bus.o_sample_vld, t <= 2098);
        end

        bus.i_en = 1'b1;
        for (int i = 0; i < 54; i++) begin
            tick(1);
            chk10("resume_dac", bus.o_dac_data, car[2'(t % 4)]);
            chk1("resume_vld", bus.o_sample_vld, t >= 2109);
            chk1("resume_strobe", bus.o_sym_strobe, t >= 2113 && ((t - 2113) % 8) == 0);
            if (t == 2146 || t == 2154) chk1("resume_bit", bus.o_cur_bit, t == 2154);
        end

        rst_n = 1'b0;
        tick(1);
        chk10("midrst_dac", bus.o_dac_data, 10'd512);
        chk1("midrst_vld", bus.o_sample_vld, 1'b0);
        chk1("midrst_strobe", bus.o_sym_strobe, 1'b0);
        chk1("midrst_bit", bus.o_cur_bit, 1'b0);
        rst_n = 1'b1;
        tick(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
